// File: rtl/sdram_controller.sv
// SDR SDRAM controller (16-bit, 4-bank): power-up init, auto-refresh, single-word write/read with auto-precharge.
// Build macro SDRAM_AUTO_REFRESH_EN enables periodic refresh; without it only the two init refreshes are issued.
`timescale 1ns/1ps
module sdram_controller #(
  parameter int INIT_CYCLES    = 50,
  parameter int TRP            = 2,
  parameter int TRCD           = 2,
  parameter int TRC            = 7,
  parameter int TMRD           = 2,
  parameter int TWR            = 2,
  parameter int CAS_LAT        = 2,
  parameter int REFRESH_CYCLES = 390
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        iwrite_req,
  input  logic [21:0] iwrite_address,
  input  logic [15:0] iwrite_data,
  output logic        owrite_ack,
  input  logic        iread_req,
  input  logic [21:0] iread_address,
  output logic [15:0] oread_data,
  output logic        oread_ack,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_CS_N,
  output logic        DRAM_CKE,
  output logic        DRAM_CLK,
  output logic        DRAM_LDQM,
  output logic        DRAM_UDQM,
  input  logic [15:0] dq_read,
  output logic [15:0] dq_write
);

  // state     | meaning
  // INIT_WAIT | CKE high, NOPs for INIT_CYCLES after reset
  // INIT_PRE  | PRECHARGE ALL
  // INIT_REF1 | first init AUTO REFRESH
  // INIT_REF2 | second init AUTO REFRESH
  // INIT_MRS  | LOAD MODE
  // IDLE      | arbitrate refresh > write > read
  // REFRESH   | periodic AUTO REFRESH
  // ACTIVATE  | open row of latched request
  // WRITE     | WRITE with auto-precharge
  // READ      | READ with auto-precharge
  // WAIT      | NOP down-count, then go to ret_state
  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS,
    IDLE, REFRESH, ACTIVATE, WRITE, READ, WAIT
  } state_t;

  typedef logic [15:0] tmr_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [12:0] MODE_WORD = {6'b000000, 3'(CAS_LAT), 4'b0000};

  state_t state, state_n, ret_state, ret_n;
  tmr_t   timer, timer_n;
  logic   is_write, is_write_n, wr_pend, wr_pend_n;
  logic [21:0] req_addr, req_addr_n;
  logic [15:0] req_data, req_data_n, dq_n;
  logic [CAS_LAT-1:0] rd_pipe;
  logic   rd_issue, wack_n, cke_n, dqm_n;
  logic [3:0]  cmd_n;
  logic [12:0] addr_n;
  logic [1:0]  ba_n;
  logic   ref_pend;

  assign DRAM_CLK = ~iclk;

`ifdef SDRAM_AUTO_REFRESH_EN
  tmr_t ref_timer;
  logic ref_clr, init_done;

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      ref_timer <= '0;
      ref_pend  <= 1'b0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      ref_timer <= tmr_t'(REFRESH_CYCLES - 1);
      ref_pend  <= 1'b0;
      init_done <= (state == IDLE);
    end else if (ref_timer == '0) begin
      ref_timer <= tmr_t'(REFRESH_CYCLES - 1);
      ref_pend  <= 1'b1;
    end else begin
      ref_timer <= ref_timer - 1'b1;
      if (ref_clr) ref_pend <= 1'b0;
    end
  end
`else
  assign ref_pend = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    ret_n      = ret_state;
    timer_n    = timer;
    cmd_n      = CMD_NOP;
    addr_n     = DRAM_ADDR;
    ba_n       = DRAM_BA;
    cke_n      = 1'b1;
    dqm_n      = DRAM_LDQM;
    dq_n       = dq_write;
    wack_n     = 1'b0;
    is_write_n = is_write;
    wr_pend_n  = wr_pend;
    req_addr_n = req_addr;
    req_data_n = req_data;
    rd_issue   = 1'b0;
`ifdef SDRAM_AUTO_REFRESH_EN
    ref_clr    = 1'b0;
`endif
    case (state)
      INIT_WAIT: begin
        if (timer == tmr_t'(INIT_CYCLES - 1)) begin
          state_n = INIT_PRE;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      INIT_PRE: begin
        cmd_n   = CMD_PRE;
        addr_n  = 13'h0400;
        state_n = WAIT;
        timer_n = tmr_t'(TRP - 1);
        ret_n   = INIT_REF1;
      end
      INIT_REF1, INIT_REF2: begin
        cmd_n   = CMD_REF;
        state_n = WAIT;
        timer_n = tmr_t'(TRC - 1);
        ret_n   = (state == INIT_REF1) ? INIT_REF2 : INIT_MRS;
      end
      INIT_MRS: begin
        cmd_n   = CMD_LMR;
        addr_n  = MODE_WORD;
        ba_n    = 2'b00;
        state_n = WAIT;
        timer_n = tmr_t'(TMRD - 1);
        ret_n   = IDLE;
      end
      IDLE: begin
        dqm_n = 1'b0;
        if (ref_pend) begin
          state_n = REFRESH;
        end else if (iwrite_req) begin
          state_n    = ACTIVATE;
          is_write_n = 1'b1;
          req_addr_n = iwrite_address;
          req_data_n = iwrite_data;
        end else if (iread_req) begin
          state_n    = ACTIVATE;
          is_write_n = 1'b0;
          req_addr_n = iread_address;
        end
      end
`ifdef SDRAM_AUTO_REFRESH_EN
      REFRESH: begin
        cmd_n   = CMD_REF;
        ref_clr = 1'b1;
        state_n = WAIT;
        timer_n = tmr_t'(TRC - 1);
        ret_n   = IDLE;
      end
`endif
      ACTIVATE: begin
        cmd_n  = CMD_ACT;
        ba_n   = req_addr[21:20];
        addr_n = {1'b0, req_addr[19:8]};
        if (TRCD > 1) begin
          state_n = WAIT;
          timer_n = tmr_t'(TRCD - 2);
          ret_n   = is_write ? WRITE : READ;
        end else begin
          state_n = is_write ? WRITE : READ;
        end
      end
      WRITE: begin
        cmd_n     = CMD_WR;
        ba_n      = req_addr[21:20];
        addr_n    = {2'b00, 1'b1, 2'b00, req_addr[7:0]};
        dq_n      = req_data;
        wr_pend_n = 1'b1;
        state_n   = WAIT;
        timer_n   = tmr_t'(TWR + TRP - 1);
        ret_n     = IDLE;
      end
      READ: begin
        cmd_n    = CMD_RD;
        ba_n     = req_addr[21:20];
        addr_n   = {2'b00, 1'b1, 2'b00, req_addr[7:0]};
        rd_issue = 1'b1;
        state_n  = WAIT;
        // hold off IDLE until the data is captured plus the precharge time
        timer_n  = tmr_t'(CAS_LAT + TRP - 1);
        ret_n    = IDLE;
      end
      WAIT: begin
        if (timer == '0) begin
          state_n = ret_state;
          if (ret_state == IDLE && wr_pend) begin
            wack_n    = 1'b1;
            wr_pend_n = 1'b0;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = INIT_WAIT;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      state      <= INIT_WAIT;
      ret_state  <= INIT_WAIT;
      timer      <= '0;
      is_write   <= 1'b0;
      wr_pend    <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      rd_pipe    <= '0;
      {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= 4'b1111;
      DRAM_CKE   <= 1'b0;
      DRAM_LDQM  <= 1'b1;
      DRAM_UDQM  <= 1'b1;
      DRAM_ADDR  <= '0;
      DRAM_BA    <= '0;
      dq_write   <= '0;
      owrite_ack <= 1'b0;
      oread_ack  <= 1'b0;
      oread_data <= '0;
    end else begin
      state      <= state_n;
      ret_state  <= ret_n;
      timer      <= timer_n;
      is_write   <= is_write_n;
      wr_pend    <= wr_pend_n;
      req_addr   <= req_addr_n;
      req_data   <= req_data_n;
      rd_pipe    <= {rd_pipe[CAS_LAT-2:0], rd_issue};
      {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= cmd_n;
      DRAM_CKE   <= cke_n;
      DRAM_LDQM  <= dqm_n;
      DRAM_UDQM  <= dqm_n;
      DRAM_ADDR  <= addr_n;
      DRAM_BA    <= ba_n;
      dq_write   <= dq_n;
      owrite_ack <= wack_n;
      oread_ack  <= rd_pipe[CAS_LAT-1];
      if (rd_pipe[CAS_LAT-1]) oread_data <= dq_read;
    end
  end

endmodule

// File: tb/tb_sdram_controller.sv
// Self-checking bench for sdram_controller: reset values, init sequence, table-driven accesses,
// write/read collision, reset abort and refresh presence against a small behavioural SDRAM model.
`timescale 1ns/1ps
module tb_sdram_controller;
  localparam int CL = 2;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100,
                         C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic        ireset, iwrite_req, iread_req, owrite_ack, oread_ack;
  logic [21:0] iwrite_address, iread_address;
  logic [15:0] iwrite_data, oread_data, dq_read, dq_write;
  logic [12:0] DRAM_ADDR;
  logic [1:0]  DRAM_BA;
  logic DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N, DRAM_CS_N, DRAM_CKE, DRAM_CLK, DRAM_LDQM, DRAM_UDQM;
  logic [3:0]  cmd;
  assign cmd = {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};

  sdram_controller dut (
    .iclk(iclk), .ireset(ireset),
    .iwrite_req(iwrite_req), .iwrite_address(iwrite_address), .iwrite_data(iwrite_data),
    .owrite_ack(owrite_ack),
    .iread_req(iread_req), .iread_address(iread_address), .oread_data(oread_data),
    .oread_ack(oread_ack),
    .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA), .DRAM_RAS_N(DRAM_RAS_N), .DRAM_CAS_N(DRAM_CAS_N),
    .DRAM_WE_N(DRAM_WE_N), .DRAM_CS_N(DRAM_CS_N), .DRAM_CKE(DRAM_CKE), .DRAM_CLK(DRAM_CLK),
    .DRAM_LDQM(DRAM_LDQM), .DRAM_UDQM(DRAM_UDQM), .dq_read(dq_read), .dq_write(dq_write)
  );

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural SDRAM: open row per bank, word memory, read data valid CL edges after READ.
  logic [15:0] mem [logic [21:0]];
  logic [11:0] open_row [4];
  int          rd_cnt = 0;
  logic [15:0] rd_val;
  bit          drv_clr = 0;

  always @(negedge iclk) begin
    if (drv_clr) begin
      dq_read = 16'h0BAD;
      drv_clr = 0;
    end
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        dq_read = rd_val;
        drv_clr = 1;
      end
    end
    case (cmd)
      C_ACT: open_row[DRAM_BA] = DRAM_ADDR[11:0];
      C_WR:  mem[{DRAM_BA, open_row[DRAM_BA], DRAM_ADDR[7:0]}] = dq_write;
      C_RD: begin
        if (mem.exists({DRAM_BA, open_row[DRAM_BA], DRAM_ADDR[7:0]}))
          rd_val = mem[{DRAM_BA, open_row[DRAM_BA], DRAM_ADDR[7:0]}];
        else
          rd_val = 16'h0BAD;
        rd_cnt = CL - 1;
      end
      default: ;
    endcase
  end

  typedef struct {
    bit          wr;
    logic [21:0] a;
    logic [15:0] d;
    logic [1:0]  ba;
    logic [12:0] act;
    logic [12:0] col;
    logic [15:0] rd;
  } vec_t;

  typedef struct {
    int          n_act, wack, rack, rw_k, ack_k;
    logic [1:0]  act_ba;
    logic [12:0] act_addr, rw_addr;
    logic [3:0]  rw_cmd;
    logic [15:0] wdata, rdata;
    logic [1:0]  dqm;
  } res_t;

  task automatic access(input bit wr, input logic [21:0] a, input logic [15:0] d, output res_t r);
    r = '{default: 0};
    if (wr) begin
      iwrite_address = a; iwrite_data = d; iwrite_req = 1'b1;
    end else begin
      iread_address = a; iread_req = 1'b1;
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge iclk);
      if (cmd == C_ACT) begin
        r.n_act++; r.act_ba = DRAM_BA; r.act_addr = DRAM_ADDR;
      end
      if (cmd == C_WR || cmd == C_RD) begin
        r.rw_cmd = cmd; r.rw_addr = DRAM_ADDR; r.rw_k = c; r.wdata = dq_write;
        r.dqm = {DRAM_UDQM, DRAM_LDQM};
      end
      if (owrite_ack) begin
        r.wack++; iwrite_req = 1'b0;
      end
      if (oread_ack) begin
        r.rack++; r.ack_k = c; r.rdata = oread_data; iread_req = 1'b0;
      end
    end
    iwrite_req = 1'b0;
    iread_req  = 1'b0;
  endtask

  vec_t vecs [7];
  res_t r;
  int pre_k, pre_a10, ref1_k, ref2_k, mrs_k, others, cke_low;
  logic [12:0] mrs_addr;
  int first_cmd, second_cmd, n_rw, wack_n, rack_n, n_act, act_seen, wr_seen, ref_n;
  logic [15:0] rdat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 22'h000000, 16'd19,   2'd0, 13'h0000, 13'h0400, 16'h0000};
    vecs[1] = '{1'b0, 22'h000000, 16'h0000, 2'd0, 13'h0000, 13'h0400, 16'd19};
    vecs[2] = '{1'b1, 22'h3ABCDE, 16'hBEEF, 2'd3, 13'h0ABC, 13'h04DE, 16'h0000};
    vecs[3] = '{1'b0, 22'h3ABCDE, 16'h0000, 2'd3, 13'h0ABC, 13'h04DE, 16'hBEEF};
    vecs[4] = '{1'b1, 22'h1FFFFF, 16'hA5A5, 2'd1, 13'h0FFF, 13'h04FF, 16'h0000};
    vecs[5] = '{1'b0, 22'h1FFFFF, 16'h0000, 2'd1, 13'h0FFF, 13'h04FF, 16'hA5A5};
    vecs[6] = '{1'b0, 22'h000000, 16'h0000, 2'd0, 13'h0000, 13'h0400, 16'd19};

    ireset = 1'b0; iwrite_req = 1'b0; iread_req = 1'b0;
    iwrite_address = '0; iread_address = '0; iwrite_data = '0; dq_read = 16'h0BAD;
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    check("rst_cke", DRAM_CKE, 0);
    check("rst_cmd", cmd, 4'b1111);
    check("rst_dqm", {DRAM_UDQM, DRAM_LDQM}, 2'b11);
    check("rst_wack", owrite_ack, 0);
    check("rst_rack", oread_ack, 0);
    check("rst_rdata", oread_data, 0);
    check("rst_addr_ba", {DRAM_BA, DRAM_ADDR}, 0);
    check("rst_dqw", dq_write, 0);

    // Init sequence: edges counted from reset release.
    ireset = 1'b1;
    pre_k = 0; pre_a10 = 0; ref1_k = 0; ref2_k = 0; mrs_k = 0; others = 0; cke_low = 0;
    mrs_addr = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge iclk);
      if (!DRAM_CKE) cke_low++;
      case (cmd)
        C_NOP: ;
        C_PRE: begin pre_k = k; pre_a10 = int'(DRAM_ADDR[10]); end
        C_REF: begin
          if (ref1_k == 0) ref1_k = k;
          else if (ref2_k == 0) ref2_k = k;
          else others++;
        end
        C_LMR: begin mrs_k = k; mrs_addr = DRAM_ADDR; end
        default: others++;
      endcase
    end
    check("init_cke_high", cke_low, 0);
    check("init_pre_cycle", pre_k, 51);
    check("init_pre_a10", pre_a10, 1);
    check("init_ref1_cycle", ref1_k, 54);
    check("init_ref2_cycle", ref2_k, 62);
    check("init_mrs_cycle", mrs_k, 70);
    check("init_mrs_word", mrs_addr, 13'h0020);
    check("init_other_cmds", others, 0);

    for (int i = 0; i < 7; i++) begin
      access(vecs[i].wr, vecs[i].a, vecs[i].d, r);
      check($sformatf("v%0d_n_act", i), r.n_act, 1);
      check($sformatf("v%0d_act_ba", i), r.act_ba, vecs[i].ba);
      check($sformatf("v%0d_act_addr", i), r.act_addr, vecs[i].act);
      check($sformatf("v%0d_col_addr", i), r.rw_addr, vecs[i].col);
      check($sformatf("v%0d_dqm", i), r.dqm, 2'b00);
      if (vecs[i].wr) begin
        check($sformatf("v%0d_wr_cmd", i), r.rw_cmd, C_WR);
        check($sformatf("v%0d_wdata", i), r.wdata, vecs[i].d);
        check($sformatf("v%0d_wack", i), r.wack, 1);
        check($sformatf("v%0d_no_rack", i), r.rack, 0);
      end else begin
        check($sformatf("v%0d_rd_cmd", i), r.rw_cmd, C_RD);
        check($sformatf("v%0d_rdata", i), r.rdata, vecs[i].rd);
        check($sformatf("v%0d_rack", i), r.rack, 1);
        check($sformatf("v%0d_cas_lat", i), r.ack_k - r.rw_k, CL);
        check($sformatf("v%0d_no_wack", i), r.wack, 0);
      end
    end

    // Simultaneous requests to one address: the write must land before the read.
    iwrite_address = 22'h000123; iwrite_data = 16'h1234; iread_address = 22'h000123;
    iwrite_req = 1'b1; iread_req = 1'b1;
    first_cmd = 0; second_cmd = 0; n_rw = 0; wack_n = 0; rack_n = 0; n_act = 0; rdat = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge iclk);
      if (cmd == C_ACT) n_act++;
      if (cmd == C_WR || cmd == C_RD) begin
        if (n_rw == 0) first_cmd = int'(cmd);
        else if (n_rw == 1) second_cmd = int'(cmd);
        n_rw++;
      end
      if (owrite_ack) begin wack_n++; iwrite_req = 1'b0; end
      if (oread_ack) begin rack_n++; rdat = oread_data; iread_req = 1'b0; end
    end
    iwrite_req = 1'b0; iread_req = 1'b0;
    check("both_first_is_write", first_cmd, C_WR);
    check("both_second_is_read", second_cmd, C_RD);
    check("both_n_act", n_act, 2);
    check("both_wack", wack_n, 1);
    check("both_rack", rack_n, 1);
    check("both_rdata", rdat, 16'h1234);

    // Reset between ACTIVE and WRITE aborts the write without ack and reruns init.
    iwrite_address = 22'h000200; iwrite_data = 16'h7777; iwrite_req = 1'b1;
    act_seen = 0; wr_seen = 0; wack_n = 0;
    for (int c = 0; c < 10 && act_seen == 0; c++) begin
      @(negedge iclk);
      if (cmd == C_ACT) act_seen = 1;
    end
    check("abort_act_seen", act_seen, 1);
    ireset = 1'b0; iwrite_req = 1'b0;
    repeat (2) @(negedge iclk);
    check("abort_rst_cke", DRAM_CKE, 0);
    check("abort_rst_cmd", cmd, 4'b1111);
    ireset = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge iclk);
      if (owrite_ack) wack_n++;
      if (cmd == C_WR) wr_seen++;
      if (k == 51) check("abort_reinit_pre", cmd, C_PRE);
    end
    check("abort_no_wack", wack_n, 0);
    check("abort_no_write", wr_seen, 0);
    access(1'b0, 22'h000200, 16'h0000, r);
    check("abort_mem_untouched", r.rdata, 16'h0BAD);
    access(1'b0, 22'h3ABCDE, 16'h0000, r);
    check("post_abort_rdata", r.rdata, 16'hBEEF);
    check("post_abort_rack", r.rack, 1);

    ref_n = 0;
    for (int k = 0; k < 900; k++) begin
      @(negedge iclk);
      if (cmd == C_REF) ref_n++;
    end
`ifdef SDRAM_AUTO_REFRESH_EN
    check("idle_refresh_seen", ref_n >= 2, 1);
`else
    check("idle_no_refresh", ref_n, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
